// File: rtl/cint_xpt_sequencer.sv
// cint_xpt_sequencer: microstep counter XPT/notXPT with interrupt-entry (CINT), IE, CM1 and sticky overflow flags
//   Inputs : CLK, notRESET (async active-low), notWAIT (low = stall), INT_REQ,
//            PR_Reset_XPT, P2_Reset_CINT, P2_Set_CM1, P2_Reset_CM1, P2_Set_IE, P2_Reset_IE
//   Outputs: XPT[4:0], notXPT[4:0], notCINT0_CALL, CM1, IE, XPT_OVF (all registered)
//   Option : define CINT_SYNC_EN to pass INT_REQ through a 2-flop synchroniser
module cint_xpt_sequencer (
  input  logic       CLK,
  input  logic       notRESET,
  input  logic       notWAIT,
  input  logic       INT_REQ,
  input  logic       PR_Reset_XPT,
  input  logic       P2_Reset_CINT,
  input  logic       P2_Set_CM1,
  input  logic       P2_Reset_CM1,
  input  logic       P2_Set_IE,
  input  logic       P2_Reset_IE,
  output logic [4:0] XPT,
  output logic [4:0] notXPT,
  output logic       notCINT0_CALL,
  output logic       CM1,
  output logic       IE,
  output logic       XPT_OVF
);
  logic [4:0] xpt_q, xpt_d, nxpt_q;
  logic       ncint_q, ncint_d, cm1_q, cm1_d, ie_q, ie_d, ovf_q, ovf_d;
  logic       int_s, entry;
`ifdef CINT_SYNC_EN
  // The synchroniser samples every cycle, stall or not, so request latency stays fixed.
  logic [1:0] sync_q;
  always_ff @(posedge CLK or negedge notRESET)
    if (!notRESET) sync_q <= 2'b00;
    else           sync_q <= {sync_q[0], INT_REQ};
  assign int_s = sync_q[1];
`else
  assign int_s = INT_REQ;
`endif
  // Entry only at an instruction boundary; a simultaneous CINT clear suppresses it.
  assign entry = PR_Reset_XPT & int_s & ie_q & ~P2_Reset_CINT;
  always_comb begin
    xpt_d   = xpt_q;
    ovf_d   = ovf_q;
    ncint_d = ncint_q;
    ie_d    = ie_q;
    cm1_d   = cm1_q;
    if (notWAIT) begin
      xpt_d   = PR_Reset_XPT ? 5'd0 : xpt_q + 5'd1;
      ovf_d   = ovf_q | (~PR_Reset_XPT & (xpt_q == 5'd31));
      ncint_d = P2_Reset_CINT ? 1'b1 : entry ? 1'b0 : ncint_q;
      ie_d    = (P2_Reset_IE | entry) ? 1'b0 : P2_Set_IE ? 1'b1 : ie_q;
      cm1_d   = P2_Reset_CM1 ? 1'b0 : P2_Set_CM1 ? 1'b1 : cm1_q;
    end
  end
  always_ff @(posedge CLK or negedge notRESET)
    if (!notRESET) begin
      xpt_q   <= 5'd0;
      nxpt_q  <= 5'h1f;
      ncint_q <= 1'b1;
      cm1_q   <= 1'b0;
      ie_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      xpt_q   <= xpt_d;
      nxpt_q  <= ~xpt_d;
      ncint_q <= ncint_d;
      cm1_q   <= cm1_d;
      ie_q    <= ie_d;
      ovf_q   <= ovf_d;
    end
  assign XPT           = xpt_q;
  assign notXPT        = nxpt_q;
  assign notCINT0_CALL = ncint_q;
  assign CM1           = cm1_q;
  assign IE            = ie_q;
  assign XPT_OVF       = ovf_q;
endmodule

// File: tb/tb_cint_xpt_sequencer.sv
// tb_cint_xpt_sequencer: directed table-driven bench for cint_xpt_sequencer (default build)
module tb_cint_xpt_sequencer;
  logic       CLK = 1'b0, notRESET = 1'b0, notWAIT = 1'b1, INT_REQ = 1'b0, PR_Reset_XPT = 1'b0;
  logic       P2_Reset_CINT = 1'b0, P2_Set_CM1 = 1'b0, P2_Reset_CM1 = 1'b0, P2_Set_IE = 1'b0, P2_Reset_IE = 1'b0;
  logic [4:0] XPT, notXPT;
  logic       notCINT0_CALL, CM1, IE, XPT_OVF;
  int         n_chk = 0, n_fail = 0;
  cint_xpt_sequencer dut (
    .CLK(CLK), .notRESET(notRESET), .notWAIT(notWAIT), .INT_REQ(INT_REQ),
    .PR_Reset_XPT(PR_Reset_XPT), .P2_Reset_CINT(P2_Reset_CINT),
    .P2_Set_CM1(P2_Set_CM1), .P2_Reset_CM1(P2_Reset_CM1),
    .P2_Set_IE(P2_Set_IE), .P2_Reset_IE(P2_Reset_IE),
    .XPT(XPT), .notXPT(notXPT), .notCINT0_CALL(notCINT0_CALL),
    .CM1(CM1), .IE(IE), .XPT_OVF(XPT_OVF)
  );
  always #5 CLK = ~CLK;
  typedef struct {
    logic       nw, irq, pr, rc, scm, rcm, sie, rie;
    logic [4:0] xpt;
    logic       ncint, cm1, ie, ovf;
  } vec_t;
  vec_t v[23];
  task automatic chk(input string nm, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask
  task automatic chk_all(input string tag, input logic [4:0] x, input logic nc, input logic c, input logic i, input logic o);
    logic [4:0] nx;
    nx = ~x;
    chk({tag, ".XPT"}, XPT, x);
    chk({tag, ".notXPT"}, notXPT, nx);
    chk({tag, ".notCINT0_CALL"}, notCINT0_CALL, nc);
    chk({tag, ".CM1"}, CM1, c);
    chk({tag, ".IE"}, IE, i);
    chk({tag, ".XPT_OVF"}, XPT_OVF, o);
  endtask
  task automatic drive(input logic nw, irq, pr, rc, scm, rcm, sie, rie);
    notWAIT = nw; INT_REQ = irq; PR_Reset_XPT = pr; P2_Reset_CINT = rc;
    P2_Set_CM1 = scm; P2_Reset_CM1 = rcm; P2_Set_IE = sie; P2_Reset_IE = rie;
  endtask
  task automatic cyc;
    @(posedge CLK);
    #1;
  endtask
  initial begin
    for (int k = 0; k < 5; k++) v[k] = '{1,0,0,0,0,0,0,0, 5'(k + 1),1,0,0,0};
    v[5]  = '{1,0,0,0,0,0,1,0, 6,1,0,1,0};
    v[6]  = '{1,0,0,0,0,0,0,0, 7,1,0,1,0};
    v[7]  = '{0,0,1,0,0,0,0,0, 7,1,0,1,0};
    v[8]  = '{0,0,1,0,0,0,0,0, 7,1,0,1,0};
    v[9]  = '{0,0,1,0,0,0,0,0, 7,1,0,1,0};
    v[10] = '{1,0,1,0,0,0,0,0, 0,1,0,1,0};
    v[11] = '{1,1,1,0,0,0,0,0, 0,0,0,0,0};
    v[12] = '{1,1,0,0,0,0,0,0, 1,0,0,0,0};
    v[13] = '{1,1,1,1,1,0,0,0, 0,1,1,0,0};
    v[14] = '{1,1,0,0,0,0,1,1, 1,1,1,0,0};
    v[15] = '{1,1,1,0,0,0,0,0, 0,1,1,0,0};
    v[16] = '{1,0,0,0,0,0,1,0, 1,1,1,1,0};
    v[17] = '{1,0,0,0,1,1,0,0, 2,1,0,1,0};
    v[18] = '{1,1,1,0,0,0,1,0, 0,0,0,0,0};
    v[19] = '{1,0,0,1,0,0,1,0, 1,1,0,1,0};
    v[20] = '{1,1,1,1,0,0,0,0, 0,1,0,1,0};
    v[21] = '{1,0,0,0,0,0,0,1, 1,1,0,0,0};
    v[22] = '{0,0,0,0,1,0,1,0, 1,1,0,0,0};
    #12;
    chk_all("reset", 0, 1, 0, 0, 0);
    notRESET = 1'b1;
    for (int k = 0; k < 23; k++) begin
      drive(v[k].nw, v[k].irq, v[k].pr, v[k].rc, v[k].scm, v[k].rcm, v[k].sie, v[k].rie);
      cyc();
      chk_all($sformatf("vec%0d", k), v[k].xpt, v[k].ncint, v[k].cm1, v[k].ie, v[k].ovf);
    end
    drive(1,1,0,0,0,0,1,0);
    cyc();
    chk_all("ie_on", 2, 1, 0, 1, 0);
    drive(1,1,0,0,0,0,0,0);
    for (int k = 0; k < 16; k++) cyc();
    chk("pre_call.XPT", XPT, 18);
    drive(1,1,1,0,0,0,0,0);
    cyc();
    chk_all("call_entry", 0, 0, 0, 0, 0);
    drive(1,1,0,0,0,0,0,0);
    for (int k = 0; k < 18; k++) cyc();
    chk_all("in_call", 18, 0, 0, 0, 0);
    drive(1,1,1,1,1,0,0,0);
    cyc();
    chk_all("call_end", 0, 1, 1, 0, 0);
    drive(1,1,0,0,0,0,0,0);
    cyc();
    chk_all("no_reentry", 1, 1, 1, 0, 0);
    drive(1,0,0,0,0,0,1,0);
    cyc();
    drive(1,0,0,0,0,0,0,0);
    #3 notRESET = 1'b0;
    #1;
    chk_all("async_reset", 0, 1, 0, 0, 0);
    notRESET = 1'b1;
    for (int k = 0; k < 31; k++) cyc();
    chk_all("at31", 31, 1, 0, 0, 0);
    cyc();
    chk_all("wrap", 0, 1, 0, 0, 1);
    drive(1,0,1,0,0,0,0,0);
    for (int k = 0; k < 3; k++) cyc();
    chk_all("ovf_sticky", 0, 1, 0, 0, 1);
    drive(1,0,0,0,0,0,0,0);
    cyc();
    chk_all("ovf_sticky2", 1, 1, 0, 0, 1);
    #3 notRESET = 1'b0;
    #2 notRESET = 1'b1;
    cyc();
    chk_all("ovf_cleared", 1, 1, 0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/cint_xpt_sequencer.md
# cint_xpt_sequencer

Step sequencer and interrupt-entry controller that feeds the per-instruction microstep decoders, including the CINT0 call decoder. It owns the 5-bit microstep counter XPT and its registered complement notXPT, the interrupt-call flag exported as notCINT0_CALL, the interrupt-enable flag and the CM1 mode flag. It consumes the decoder's end-of-sequence strobes PR_Reset_XPT, P2_Reset_CINT and P2_Set_CM1.

## Interface
- No parameters; XPT width fixed at 5.
- CLK  in  1  system clock; all state changes on rising edge.
- notRESET  in  1  asynchronous, active-low reset.
- notWAIT  in  1  low = memory/bus stall; all synchronous state holds.
- INT_REQ  in  1  level-sensitive external interrupt request.
- PR_Reset_XPT  in  1  clear XPT to 0; marks instruction boundary.
- P2_Reset_CINT  in  1  clear CINT flag.
- P2_Set_CM1 / P2_Reset_CM1  in  1 each  set / clear CM1.
- P2_Set_IE / P2_Reset_IE  in  1 each  set / clear interrupt enable.
- XPT  out  5  current microstep.
- notXPT  out  5  bitwise complement of XPT, registered.
- notCINT0_CALL  out  1  low while an interrupt call sequence is active.
- CM1  out  1  CM1 mode flag.
- IE  out  1  interrupt-enable flag.
- XPT_OVF  out  1  sticky: XPT incremented past 31.

## Operation
- Reset (notRESET low, asynchronous): XPT=0, notXPT=5'b11111, notCINT0_CALL=1, CM1=0, IE=0, XPT_OVF=0.
- notWAIT=0: every register holds; all strobes ignored that cycle. Decoder strobes stay asserted through a stall, so the action takes effect on the first cycle with notWAIT=1.
- XPT, per cycle with notWAIT=1: PR_Reset_XPT → 0; else XPT+1 modulo 32. notXPT updated from the same next-state value; notXPT == ~XPT in every cycle.
- Overflow: increment from 31 without PR_Reset_XPT → XPT=0 and XPT_OVF=1; XPT_OVF cleared only by reset.
- Interrupt entry: request term INT_S (INT_REQ, or its synchronised copy, see Configuration). On a cycle with notWAIT=1, PR_Reset_XPT=1, INT_S=1, IE=1 and P2_Reset_CINT=0 → CINT set (notCINT0_CALL=0) and IE cleared in the same edge. Taken only at a boundary; XPT restarts at 0 for the call sequence.
- CINT clear: P2_Reset_CINT=1 → CINT=0; clear beats set in the same cycle. IE was cleared at entry, so the step that ends the call cannot retrigger.
- IE: P2_Reset_IE beats P2_Set_IE; interrupt entry clears IE regardless of P2_Set_IE.
- CM1: P2_Reset_CM1 beats P2_Set_CM1.
- INT_REQ is not latched; a request that drops before a boundary with IE=1 is lost.

## Timing
- All outputs registered, change only on CLK rise, or on async reset assertion.
- XPT advances one step per non-stalled cycle; step after PR_Reset_XPT is 0, then 1.
- Strobe to flag change: 1 edge.
- INT_REQ to notCINT0_CALL falling: 1 edge after the qualifying boundary cycle, plus 2 cycles with synchroniser.
- Reset deassertion mid-sequence: resumes from XPT=0, all flags cleared; no partial call sequence survives.

## Configuration
- CINT_SYNC_EN defined: INT_REQ passes through a 2-flop synchroniser, both flops reset to 0; INT_S is the second flop; 2 cycles extra request latency.
- CINT_SYNC_EN undefined: INT_S = INT_REQ directly; INT_REQ must be synchronous to CLK.

## Test plan
- Reset then 5 free cycles, notWAIT=1 → XPT 0,1,2,3,4,5; notXPT 31,30,29,28,27,26; flags 0, notCINT0_CALL=1.
- XPT=7, notWAIT=0 for 3 cycles with PR_Reset_XPT=1 → XPT holds 7; PR_Reset_XPT held into first non-stalled cycle → XPT=0.
- IE=1, INT_REQ=1, PR_Reset_XPT at XPT=18 → next edge notCINT0_CALL=0, IE=0, XPT=0; with CINT_SYNC_EN INT_REQ must lead boundary by ≥2 cycles.
- During the call at XPT=18 assert PR_Reset_XPT, P2_Reset_CINT, P2_Set_CM1 with INT_REQ still 1 → notCINT0_CALL=1, CM1=1, XPT=0, no re-entry because IE=0.
- IE=0, INT_REQ=1, boundary → no entry; P2_Set_IE and P2_Reset_IE together → IE stays 0.
- 32 cycles with no PR_Reset_XPT from 0 → XPT wraps 31→0, XPT_OVF=1 and stays 1 until notRESET pulse.
